mips_controller: RTL
====================

Name: mips_controller

Overview:
- Multicycle control FSM for the MIPS core; sits directly upstream of the multicycle datapath and drives all of its select/enable inputs.
- Consumes op, funct and zero from the datapath; produces one control word per cycle, plus memwrite for the memory interface.
- Each instruction takes 3 to 5 cycles: FETCH, DECODE, then per-class execute/memory/writeback states.

Parameters:
- OP_LW, 6'b100011, load-word opcode
- OP_SW, 6'b101011, store-word opcode
- OP_RTYPE, 6'b000000, R-type opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous active-high reset
- op  in  6  instr[31:26] from datapath
- funct  in  6  instr[5:0] from datapath
- zero  in  1  ALU zero flag (combinational, same cycle)
- alusra  out  1  ALU src A: 0=pc, 1=A reg
- alusrcb  out  2  ALU src B: 00=B reg, 01=one, 10=imm, 11=imm<<2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsource  out  2  00=aluresult, 01=aluout, 10=jump target, 11=zero
- pcen  out  1  PC load = pcwrite | (branch & zero)
- iord  out  1  address select: 0=pc, 1=aluout
- irwrite  out  1  instruction register load
- memtoreg  out  1  writeback data: 0=aluout, 1=mdr
- regdst  out  1  write-register select: 0=rt, 1=rd
- regwrite  out  1  register file write
- memwrite  out  1  data memory write strobe
- state  out  4  current state encoding (debug/verification)

Behaviour:
- Moore FSM; outputs decode from state only, except pcen, which also uses zero. Any output not listed for a state is 0, and alucontrol defaults to 010.
- Reset: while reset=1, the state register loads FETCH. All enables (pcen, irwrite, regwrite, memwrite) are forced to 0 and all selects to 0. The first cycle after release executes FETCH.
- Reset mid-instruction aborts it: no write occurs in the reset cycle.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11
  - BNEEX=12 (only with the optional feature)
- FETCH: iord=0, alusra=0, alusrcb=01, add, pcsource=00, irwrite=1, pcwrite=1. Next: DECODE.
- DECODE: alusra=0, alusrcb=11, add (branch target into aluout). Next by op:
  - lw/sw: MEMADR
  - R-type: RTYPEEX
  - beq: BEQEX
  - addi: ADDIEX
  - j: JEX
  - any other op: FETCH (illegal opcode = no-op, no writes)
- MEMADR: alusra=1, alusrcb=10, add. Next: MEMRD if op=lw, MEMWR if op=sw.
- MEMRD: iord=1. Next: MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: iord=1, memwrite=1. Next: FETCH.
- RTYPEEX: alusra=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - any other funct -> 010
  - Next: RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BEQEX: alusra=1, alusrcb=00, sub, pcsource=01, branch=1, so pcen=zero. Next: FETCH.
- ADDIEX: alusra=1, alusrcb=10, add. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JEX: pcsource=10, pcwrite=1. Next: FETCH.
- Cycle counts per instruction: lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
- At most one of regwrite/memwrite/irwrite is high in any cycle.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: op 6'b000101 in DECODE -> BNEEX. BNEEX drives the same control word as BEQEX, but pcen = ~zero. Next: FETCH.
- Undefined: op 000101 is illegal (DECODE -> FETCH), state value 12 is unreachable, and no BNEEX logic is generated.

Test Plan:
- Reset held 2 cycles mid-RTYPEEX, then released -> during reset pcen=irwrite=regwrite=memwrite=0. Next cycle state=0, irwrite=1, pcen=1.
- op=100011 -> states 0,1,2,3,4,0. In state 4: regwrite=1, memtoreg=1, regdst=0. In state 3: iord=1. memwrite=0 throughout.
- op=000000, funct=101010 -> states 0,1,6,7,0. alucontrol=111 in state 6. regwrite=1, regdst=1 in state 7.
- op=000100 with zero=1, then a second beq with zero=0 -> BEQEX pcen=1 then 0. pcsource=01 and alucontrol=110 both times.
- op=101011, then op=000010 -> sw: states 0,1,2,5,0 with memwrite=1 only in state 5. j: states 0,1,11,0 with pcsource=10, pcen=1.
- op=000101 -> with MIPS_CTRL_BNE_EN: state 12, pcen=~zero. Without: DECODE -> FETCH, with no write enable asserted in the DECODE cycle.

Source files
------------

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: one control word per cycle from the current state (pcen also uses zero).
// Optional bne support via `define MIPS_CTRL_BNE_EN (adds state BNEEX=12).
module mips_controller #(
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       alusra,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       memwrite,
    output logic [3:0] state
);
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MIPS_CTRL_BNE_EN
        ,
        S_BNEEX   = 4'd12
`endif
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_pcwrite;
    logic   w_branch;
    logic   w_branch_n;

    function automatic logic [2:0] f_alu_decode(input logic [5:0] f);
        case (f)
            6'b100000: f_alu_decode = 3'b010;
            6'b100010: f_alu_decode = 3'b110;
            6'b100100: f_alu_decode = 3'b000;
            6'b100101: f_alu_decode = 3'b001;
            6'b101010: f_alu_decode = 3'b111;
            default:   f_alu_decode = 3'b010;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        alusra     = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b010;
        pcsource   = 2'b00;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_branch_n = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (op == OP_LW || op == OP_SW) w_next = S_MEMADR;
                else if (op == OP_RTYPE)        w_next = S_RTYPEEX;
                else if (op == OP_BEQ)          w_next = S_BEQEX;
                else if (op == OP_ADDI)         w_next = S_ADDIEX;
                else if (op == OP_J)            w_next = S_JEX;
`ifdef MIPS_CTRL_BNE_EN
                else if (op == OP_BNE)          w_next = S_BNEEX;
`endif
                else                            w_next = S_FETCH;
            end
            S_MEMADR: begin
                alusra  = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusra     = 1'b1;
                alucontrol = f_alu_decode(funct);
                w_next     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusra     = 1'b1;
                alucontrol = 3'b110;
                pcsource   = 2'b01;
                w_branch   = 1'b1;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNEEX: begin
                alusra     = 1'b1;
                alucontrol = 3'b110;
                pcsource   = 2'b01;
                w_branch_n = 1'b1;
            end
`endif
            S_ADDIEX: begin
                alusra  = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsource  = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        // Reset aborts the instruction in flight: nothing is written and all selects idle.
        if (reset) begin
            alusra     = 1'b0;
            alusrcb    = 2'b00;
            pcsource   = 2'b00;
            iord       = 1'b0;
            irwrite    = 1'b0;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            w_pcwrite  = 1'b0;
            w_branch   = 1'b0;
            w_branch_n = 1'b0;
        end
    end

    assign pcen  = w_pcwrite | (w_branch & zero) | (w_branch_n & ~zero);
    assign state = r_state;
endmodule
